bus_transfer_sequencer: RTL and testbench

BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

---
 rtl/bus_transfer_sequencer.sv | 114 +++++++++++
 tb/tb_bus_transfer_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// Register-to-register transfer sequencer for a shared tri-state bus.
// One transfer at a time: drive the source, then load the destination, then report.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module bus_transfer_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IDX_W-1:0]       req_src,
    input  logic [IDX_W-1:0]       req_dst,
    input  logic [`DATA_WIDTH-1:0] bus,
    output logic [NUM_REGS-1:0]    regEnable,
    output logic [NUM_REGS-1:0]    regLoad,
    output logic                   done_valid,
    output logic [`DATA_WIDTH-1:0] done_data,
    output logic                   done_error,
    output logic [15:0]            xfer_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, DONE} state_t;

    localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         src_q, src_d, dst_q, dst_d;
    logic [NUM_REGS-1:0]      en_q, en_d, ld_q, ld_d;
    logic [`DATA_WIDTH-1:0]   data_q, data_d;
    logic                     err_q, err_d;
    logic [15:0]              cnt_q, cnt_d;
    logic                     accept, legal;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign legal     = (req_src != req_dst) && ({1'b0, req_src} < NREGS)
                       && ({1'b0, req_dst} < NREGS);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    src_d = req_src;
                    dst_d = req_dst;
                    if (legal) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            DRIVE: state_d = LOAD;
            LOAD: begin
                state_d = DONE;
                data_d  = bus;
                err_d   = 1'b0;
                cnt_d   = cnt_q + 16'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they come straight out of flops.
    always_comb begin
        en_d = '0;
        ld_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            en_d[i] = ((state_d == DRIVE) || (state_d == LOAD)) && (src_d == IDX_W'(i));
            ld_d[i] = (state_d == LOAD) && (dst_d == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            en_q    <= '0;
            ld_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            en_q    <= en_d;
            ld_q    <= ld_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign regEnable  = en_q;
    assign regLoad    = ld_q;
    assign done_valid = (state_q == DONE);
    assign done_data  = data_q;
    assign done_error = err_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: table vectors, random transfers against a
// timeline reference, and hand sequences for back-to-back, reset and wrap cases.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_bus_transfer_sequencer;

    localparam int N  = 8;
    localparam int IW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, req_valid, req_ready;
    logic [IW-1:0] req_src, req_dst;
    logic [7:0]    bus;
    logic [N-1:0]  reg_en, reg_ld;
    logic          done_valid, done_error;
    logic [7:0]    done_data;
    logic [15:0]   xfer_count;

    logic          r6_valid, r6_ready;
    logic [2:0]    r6_src, r6_dst;
    logic [7:0]    bus6;
    logic [5:0]    r6_en, r6_ld;
    logic          r6_dv, r6_err;
    logic [7:0]    r6_data;
    logic [15:0]   r6_cnt;

    logic [7:0]    mem [N];
    int            n_chk = 0;
    int            n_fail = 0;
    logic [15:0]   model_cnt;
    logic [7:0]    model_data;

    bus_transfer_sequencer #(.NUM_REGS(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .bus(bus),
        .regEnable(reg_en), .regLoad(reg_ld), .done_valid(done_valid),
        .done_data(done_data), .done_error(done_error), .xfer_count(xfer_count)
    );

    bus_transfer_sequencer #(.NUM_REGS(6)) dut6 (
        .clk(clk), .reset(reset), .req_valid(r6_valid), .req_ready(r6_ready),
        .req_src(r6_src), .req_dst(r6_dst), .bus(bus6),
        .regEnable(r6_en), .regLoad(r6_ld), .done_valid(r6_dv),
        .done_data(r6_data), .done_error(r6_err), .xfer_count(r6_cnt)
    );

    // Bus model: the enabled register drives the bus, otherwise it reads as zero.
    always_comb begin
        bus = 8'h00;
        for (int i = 0; i < N; i++) if (reg_en[i]) bus = mem[i];
    end
    assign bus6 = (r6_en != 6'd0) ? 8'h5A : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic prop(input string name, input bit ok, input logic [31:0] act);
        n_chk++;
        assert (ok) else begin
            n_fail++;
            $display("FAIL %s: strobes %0h violate property", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        prop("onehot_en", $onehot0(reg_en), reg_en);
        prop("onehot_ld", $onehot0(reg_ld), reg_ld);
        prop("ld_needs_en", (reg_ld == '0) || (reg_en != '0), {reg_ld, reg_en});
        prop("onehot_en6", $onehot0(r6_en), r6_en);
        prop("onehot_ld6", $onehot0(r6_ld), r6_ld);
        prop("ld_needs_en6", (r6_ld == '0) || (r6_en != '0), {r6_ld, r6_en});
    endtask

    // Legal transfers show DRIVE, LOAD, DONE in cycles 1..3 after acceptance;
    // rejected ones go straight to DONE in cycle 1.
    task automatic xfer(input logic [2:0] s, input logic [2:0] d, input bit exp_err,
                        input logic [7:0] exp_data, input string tag);
        int w;
        int lat;
        logic [7:0] exp_en, exp_ld;
        w = 0;
        while (!req_ready && w < 10) begin step(); w++; end
        chk({tag, ".ready"}, req_ready, 1);
        req_valid = 1'b1; req_src = s; req_dst = d;
        step();
        req_valid = 1'b0;
        req_src = 3'($urandom);
        req_dst = 3'($urandom);
        lat = exp_err ? 1 : 3;
        if (!exp_err) model_cnt = model_cnt + 16'd1;
        for (int c = 1; c <= lat; c++) begin
            exp_en = (!exp_err && c <= 2) ? 8'(8'd1 << s) : 8'h00;
            exp_ld = (!exp_err && c == 2) ? 8'(8'd1 << d) : 8'h00;
            chk({tag, ".en"}, reg_en, exp_en);
            chk({tag, ".ld"}, reg_ld, exp_ld);
            chk({tag, ".dv"}, done_valid, (c == lat));
            if (c < lat) begin
                req_valid = 1'($urandom_range(0, 1));
                step();
            end
        end
        req_valid = 1'b0;
        chk({tag, ".err"}, done_error, exp_err);
        chk({tag, ".data"}, done_data, exp_data);
        chk({tag, ".cnt"}, xfer_count, model_cnt);
        model_data = exp_data;
        step();
        chk({tag, ".dv_off"}, done_valid, 0);
        chk({tag, ".ready_after"}, req_ready, 1);
        chk({tag, ".data_hold"}, done_data, exp_data);
        chk({tag, ".err_hold"}, done_error, exp_err);
    endtask

    typedef struct {
        logic [2:0] src;
        logic [2:0] dst;
        bit         err;
        logic [7:0] data;
    } vec_t;

    typedef struct {
        logic [2:0] src;
        logic [2:0] dst;
        bit         err;
    } vec6_t;

    initial begin
        vec_t  tbl [7];
        vec6_t t6 [4];
        logic [2:0] ps [3];
        logic [2:0] pd [3];
        int acc [3];
        int k, cyc;
        logic [2:0] s, d;
        bit e;

        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hA5; mem[3] = 8'h33;
        mem[4] = 8'h44; mem[5] = 8'h55; mem[6] = 8'h66; mem[7] = 8'h77;
        tbl[0] = '{3'd2, 3'd5, 1'b0, 8'hA5};
        tbl[1] = '{3'd3, 3'd3, 1'b1, 8'hA5};
        tbl[2] = '{3'd0, 3'd7, 1'b0, 8'h11};
        tbl[3] = '{3'd7, 3'd0, 1'b0, 8'h77};
        tbl[4] = '{3'd6, 3'd6, 1'b1, 8'h77};
        tbl[5] = '{3'd4, 3'd1, 1'b0, 8'h44};
        tbl[6] = '{3'd5, 3'd5, 1'b1, 8'h44};
        t6[0] = '{3'd1, 3'd7, 1'b1};
        t6[1] = '{3'd6, 3'd0, 1'b1};
        t6[2] = '{3'd7, 3'd7, 1'b1};
        t6[3] = '{3'd5, 3'd0, 1'b0};

        // Reset with a request pending: reset wins, everything reads zero.
        reset = 1'b1; req_valid = 1'b1; req_src = 3'd2; req_dst = 3'd5;
        r6_valid = 1'b0; r6_src = 3'd0; r6_dst = 3'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst.en", reg_en, 0);
            chk("rst.ld", reg_ld, 0);
            chk("rst.dv", done_valid, 0);
            chk("rst.err", done_error, 0);
            chk("rst.data", done_data, 0);
            chk("rst.cnt", xfer_count, 0);
            chk("rst.ready", req_ready, 0);
        end
        reset = 1'b0; req_valid = 1'b0;
        step();
        chk("rst.ready_after", req_ready, 1);
        chk("rst.no_accept", reg_en, 0);
        model_cnt = 16'd0;
        model_data = 8'h00;

        for (int i = 0; i < 7; i++)
            xfer(tbl[i].src, tbl[i].dst, tbl[i].err, tbl[i].data, $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) mem[$urandom_range(0, 7)] = 8'($urandom);
            s = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 3) == 0) ? s : 3'($urandom_range(0, 7));
            e = (s == d);
            xfer(s, d, e, e ? model_data : mem[s], $sformatf("rnd%0d", i));
        end

        // Back-to-back: req_valid stays high across three transfers.
        ps[0] = 3'd0; ps[1] = 3'd2; ps[2] = 3'd4;
        pd[0] = 3'd1; pd[1] = 3'd3; pd[2] = 3'd5;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        k = 0; cyc = 0;
        req_valid = 1'b1; req_src = ps[0]; req_dst = pd[0];
        while (k < 3 && cyc < 40) begin
            if (req_ready) begin
                acc[k] = cyc;
                k++;
                step(); cyc++;
                if (k < 3) begin req_src = ps[k]; req_dst = pd[k]; end
            end else begin
                step(); cyc++;
            end
        end
        req_valid = 1'b0;
        chk("b2b.accepts", k, 3);
        chk("b2b.gap1", acc[1] - acc[0], 4);
        chk("b2b.gap2", acc[2] - acc[1], 4);
        step(); step();
        model_cnt = model_cnt + 16'd3;
        model_data = mem[4];
        chk("b2b.dv", done_valid, 1);
        chk("b2b.cnt", xfer_count, model_cnt);
        chk("b2b.data", done_data, model_data);
        step();

        // Reset arriving in the LOAD cycle.
        req_valid = 1'b1; req_src = 3'd1; req_dst = 3'd2;
        step();
        req_valid = 1'b0;
        step();
        chk("mid.load_en", reg_en, 8'h02);
        chk("mid.load_ld", reg_ld, 8'h04);
        reset = 1'b1; req_valid = 1'b1;
        step();
        chk("mid.en", reg_en, 0);
        chk("mid.ld", reg_ld, 0);
        chk("mid.dv", done_valid, 0);
        chk("mid.err", done_error, 0);
        chk("mid.data", done_data, 0);
        chk("mid.cnt", xfer_count, 0);
        chk("mid.ready", req_ready, 0);
        reset = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid.no_done", done_valid, 0);
            chk("mid.idle_en", reg_en, 0);
        end
        model_cnt = 16'd0;
        model_data = 8'h00;

        // Counter wrap: hold the count at FFFF across one idle edge, then transfer.
        force dut.cnt_q = 16'hFFFF;
        step();
        release dut.cnt_q;
        chk("wrap.pre", xfer_count, 16'hFFFF);
        model_cnt = 16'hFFFF;
        xfer(3'd1, 3'd6, 1'b0, mem[1], "wrap");
        chk("wrap.zero", xfer_count, 0);

        // Six-register instance: indices 6 and 7 are out of range.
        for (int i = 0; i < 4; i++) begin
            chk("r6.ready", r6_ready, 1);
            r6_valid = 1'b1; r6_src = t6[i].src; r6_dst = t6[i].dst;
            step();
            r6_valid = 1'b0;
            if (t6[i].err) begin
                chk("r6.dv", r6_dv, 1);
                chk("r6.err", r6_err, 1);
                chk("r6.en", r6_en, 0);
                chk("r6.ld", r6_ld, 0);
                chk("r6.cnt", r6_cnt, 0);
            end else begin
                chk("r6.drive_en", r6_en, 6'h20);
                step();
                chk("r6.load_ld", r6_ld, 6'h01);
                step();
                chk("r6.ok_dv", r6_dv, 1);
                chk("r6.ok_err", r6_err, 0);
                chk("r6.ok_data", r6_data, 8'h5A);
                chk("r6.ok_cnt", r6_cnt, 1);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
